// File: rtl/image_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_feeder_pkg
// Description : Shared sizes, bank/read-FSM state types and the pixel store
//               transform for the image_feeder slice.
//               Optional: IMAGE_FEEDER_BINARIZE_EN stores pixels as +1/-1.
// Revision    : 1.0 - initial release
// ============================================================================
package image_feeder_pkg;

    localparam int DW     = 32;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int PW     = $clog2(NPIX);
    localparam int THRESH = 128;

    typedef enum logic [1:0] {
        B_FREE    = 2'd0,
        B_FULL    = 2'd1,
        B_READING = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_START  = 2'd1,
        R_STREAM = 2'd2,
        R_WAIT   = 2'd3
    } rd_state_t;

    function automatic logic [DW-1:0] store_word(input logic [DW-1:0] d);
`ifdef IMAGE_FEEDER_BINARIZE_EN
        return (d >= DW'(THRESH)) ? DW'(1) : '1;
`else
        return d;
`endif
    endfunction

endpackage : image_feeder_pkg
`default_nettype wire

// File: rtl/image_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : image_feeder_if
// Description : Pixel-stream input and CNN-core side signals of image_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
import image_feeder_pkg::*;

interface image_feeder_if;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          cnn_start;
    logic [DW-1:0] cnn_din;
    logic          cnn_din_ready;
    logic          cnn_done;
    logic          frame_err;
    logic          busy;

    modport slave (
        input  s_valid, s_data, s_last, cnn_din_ready, cnn_done,
        output s_ready, cnn_start, cnn_din, frame_err, busy
    );

    modport master (
        output s_valid, s_data, s_last, cnn_din_ready, cnn_done,
        input  s_ready, cnn_start, cnn_din, frame_err, busy
    );
endinterface : image_feeder_if
`default_nettype wire

// File: rtl/image_feeder_frame_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : frame_bank_ram
// Description : Simple dual-port synchronous RAM, one write and one read port,
//               one-cycle read latency. Address is {bank, pointer}.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_bank_ram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [DW-1:0] wdata,
    input  wire logic [AW-1:0] raddr,
    output logic      [DW-1:0] rdata
);
    logic [DW-1:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        rdata <= r_mem[raddr];
    end
endmodule : frame_bank_ram
`default_nettype wire

// File: rtl/image_feeder.sv
`default_nettype none
// ============================================================================
// Module      : image_feeder
// Description : Ping-pong frame store between a pixel stream and the CNN core.
//               Optional: IMAGE_FEEDER_BINARIZE_EN stores pixels as +1/-1.
// Revision    : 1.0 - initial release
// ============================================================================
module image_feeder
    import image_feeder_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rstn,
    image_feeder_if.slave bus
);
    localparam logic [PW-1:0] c_last = PW'(NPIX - 1);

    bank_state_t   r_bank_st [2];
    rd_state_t     r_rstate;
    logic          r_rdy_en, r_drop, r_err, r_wbank;
    logic          r_rbank, r_start, r_stream;
    logic [PW-1:0] r_wptr, r_rptr;

    logic          w_ready, w_acc, w_we, w_load_done, w_take, w_free, w_consume;
    logic [PW-1:0] w_rptr_nxt;
    logic [DW-1:0] w_rdata;

    // s_ready depends only on registers, so a same-cycle cnn_done cannot reach it
    assign w_ready     = r_rdy_en & (r_drop | (r_bank_st[r_wbank] == B_FREE));
    assign w_acc       = bus.s_valid & w_ready;
    assign w_we        = w_acc & ~r_drop;
    assign w_load_done = w_we & (r_wptr == c_last) & bus.s_last;
    assign w_take      = (r_rstate == R_START);
    assign w_free      = (r_rstate == R_WAIT) & bus.cnn_done;
    assign w_consume   = r_stream & bus.cnn_din_ready;
    // Reading ahead with the post-consume pointer keeps the RAM output equal to word rptr
    assign w_rptr_nxt  = w_consume ? r_rptr + PW'(1) : r_rptr;

    frame_bank_ram #(.AW(PW + 1), .DW(DW)) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr ({r_wbank, r_wptr}),
        .wdata (store_word(bus.s_data)),
        .raddr ({r_rbank, w_rptr_nxt}),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdy_en <= 1'b0;
            r_drop   <= 1'b0;
            r_err    <= 1'b0;
            r_wbank  <= 1'b0;
            r_wptr   <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            r_err    <= 1'b0;
            if (w_acc) begin
                if (r_drop) begin
                    if (bus.s_last) r_drop <= 1'b0;
                end else if (r_wptr == c_last) begin
                    r_wptr <= '0;
                    if (bus.s_last) begin
                        r_wbank <= ~r_wbank;
                    end else begin
                        r_drop <= 1'b1;
                        r_err  <= 1'b1;
                    end
                end else if (bus.s_last) begin
                    r_wptr <= '0;
                    r_err  <= 1'b1;
                end else begin
                    r_wptr <= r_wptr + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 2; b++) r_bank_st[b] <= B_FREE;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_load_done && r_wbank == 1'(b)) r_bank_st[b] <= B_FULL;
                if (w_take && r_rbank == 1'(b))      r_bank_st[b] <= B_READING;
                if (w_free && r_rbank == 1'(b))      r_bank_st[b] <= B_FREE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rstate <= R_IDLE;
            r_rbank  <= 1'b0;
            r_rptr   <= '0;
            r_start  <= 1'b0;
            r_stream <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (r_bank_st[r_rbank] == B_FULL) begin
                        r_rstate <= R_START;
                        r_start  <= 1'b1;
                        r_rptr   <= '0;
                    end
                end
                R_START: begin
                    r_start  <= 1'b0;
                    r_stream <= 1'b1;
                    r_rstate <= R_STREAM;
                end
                R_STREAM: begin
                    if (bus.cnn_din_ready) begin
                        if (r_rptr == c_last) begin
                            r_rptr   <= '0;
                            r_stream <= 1'b0;
                            r_rstate <= R_WAIT;
                        end else begin
                            r_rptr <= r_rptr + PW'(1);
                        end
                    end
                end
                R_WAIT: begin
                    if (bus.cnn_done) begin
                        r_rbank  <= ~r_rbank;
                        r_rstate <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign bus.s_ready   = w_ready;
    assign bus.cnn_start = r_start;
    assign bus.cnn_din   = r_stream ? w_rdata : '0;
    assign bus.frame_err = r_err;
    assign bus.busy      = (r_bank_st[0] != B_FREE) | (r_bank_st[1] != B_FREE);

endmodule : image_feeder
`default_nettype wire

// File: tb/tb_image_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_image_feeder
// Description : Directed self-checking bench for image_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_image_feeder;
    import image_feeder_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    image_feeder_if bus();

    image_feeder dut (.clk(clk), .rstn(rstn), .bus(bus));

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] rx[$];
    bit          mon_act = 1'b0;
    int          mon_cnt = 0;
    int          n_start = 0;
    int          n_err   = 0;
    bit          dr_en   = 1'b0;
    bit          dr_rnd  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_pix(input int v);
`ifdef IMAGE_FEEDER_BINARIZE_EN
        return (v >= 128) ? 32'd1 : 32'hFFFF_FFFF;
`else
        return 32'(v);
`endif
    endfunction

    always @(posedge clk) begin
        #1;
        bus.cnn_din_ready = dr_rnd ? ($urandom_range(0, 99) < 30) : dr_en;
    end

    // Records every word the core consumes between a cnn_start and the NPIX-th consume
    always @(negedge clk) begin
        if (!rstn) begin
            mon_act = 1'b0;
        end else begin
            if (mon_act && bus.cnn_din_ready) begin
                rx.push_back(bus.cnn_din);
                mon_cnt++;
                if (mon_cnt == NPIX) mon_act = 1'b0;
            end
            if (bus.cnn_start) begin
                n_start++;
                mon_act = 1'b1;
                mon_cnt = 0;
            end
            if (bus.frame_err) n_err++;
        end
    end

    task automatic push(input logic [31:0] d, input bit l, output bit ok);
        int t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        while (!bus.s_ready && t < 4000) begin
            @(negedge clk);
            t++;
        end
        ok = bus.s_ready;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_at, input int base, output int nrej);
        bit ok;
        nrej = 0;
        for (int i = 0; i < n; i++) begin
            push(32'(base + i), (i == last_at), ok);
            if (!ok) nrej++;
        end
    endtask

    task automatic wait_rx(input string tag, input int n);
        int t = 0;
        while (rx.size() < n && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_rxcnt"}, 32'(rx.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int off, input int base);
        int bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (off + i >= rx.size()) bad++;
            else if (rx[off + i] !== exp_pix(base + i)) bad++;
        end
        chk({tag, "_badwords"}, 32'(bad), 32'd0);
        if (rx.size() > off) chk({tag, "_first"}, rx[off], exp_pix(base));
    endtask

    task automatic pulse_done();
        @(negedge clk);
        bus.cnn_done = 1'b1;
        @(negedge clk);
        bus.cnn_done = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd0);
        chk({tag, "_start"},   32'(bus.cnn_start), 32'd0);
        chk({tag, "_din"},     bus.cnn_din, 32'd0);
        chk({tag, "_err"},     32'(bus.frame_err), 32'd0);
        chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rej, s0, e0;
        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_last   = 1'b0;
        bus.cnn_done = 1'b0;

        repeat (3) @(negedge clk);
        #1 chk_reset_outs("rst");
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("rst_first_cycle_ready", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        chk("rst_ready_after", 32'(bus.s_ready), 32'd1);

        // 1) single frame, din_ready held high
        dr_en = 1'b1;
        rx.delete();
        s0 = n_start;
        send_frame(NPIX, NPIX - 1, 0, rej);
        chk("t1_rejected", 32'(rej), 32'd0);
        wait_rx("t1", NPIX);
        check_frame("t1", 0, 0);
        chk("t1_px127", rx[127], exp_pix(127));
        chk("t1_px128", rx[128], exp_pix(128));
        chk("t1_px783", rx[783], exp_pix(783));
        chk("t1_starts", 32'(n_start - s0), 32'd1);
        chk("t1_din_wait", bus.cnn_din, 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        pulse_done();
        repeat (2) @(negedge clk);
        chk("t1_busy_after", 32'(bus.busy), 32'd0);

        // 2) two frames back to back without cnn_done
        rx.delete();
        s0 = n_start;
        send_frame(NPIX, NPIX - 1, 2000, rej);
        send_frame(NPIX, NPIX - 1, 3000, rej);
        chk("t2_rejected", 32'(rej), 32'd0);
        wait_rx("t2a", NPIX);
        chk("t2_ready_both_used", 32'(bus.s_ready), 32'd0);
        chk("t2_starts_a", 32'(n_start - s0), 32'd1);
        @(negedge clk);
        bus.cnn_done = 1'b1;
        #1 chk("t2_ready_same_cycle", 32'(bus.s_ready), 32'd0);
        @(negedge clk);
        bus.cnn_done = 1'b0;
        chk("t2_ready_freed", 32'(bus.s_ready), 32'd1);
        wait_rx("t2b", 2 * NPIX);
        check_frame("t2a", 0, 2000);
        check_frame("t2b", NPIX, 3000);
        chk("t2_starts_b", 32'(n_start - s0), 32'd2);
        pulse_done();

        // 3) ~30% din_ready duty
        dr_rnd = 1'b1;
        rx.delete();
        send_frame(NPIX, NPIX - 1, 4000, rej);
        wait_rx("t3", NPIX);
        repeat (10) @(negedge clk);
        chk("t3_no_extra", 32'(rx.size()), 32'(NPIX));
        check_frame("t3", 0, 4000);
        dr_rnd = 1'b0;
        pulse_done();

        // 4) early s_last
        rx.delete();
        s0 = n_start;
        e0 = n_err;
        send_frame(100, 99, 0, rej);
        repeat (6) @(negedge clk);
        chk("t4_err", 32'(n_err - e0), 32'd1);
        chk("t4_no_start", 32'(n_start - s0), 32'd0);
        send_frame(NPIX, NPIX - 1, 5000, rej);
        wait_rx("t4", NPIX);
        check_frame("t4", 0, 5000);
        pulse_done();

        // 5) missing s_last, then 5 more beats ending the garbage frame
        rx.delete();
        s0 = n_start;
        e0 = n_err;
        send_frame(NPIX, -1, 0, rej);
        send_frame(5, 4, 0, rej);
        chk("t5_drop_ready", 32'(rej), 32'd0);
        repeat (6) @(negedge clk);
        chk("t5_err", 32'(n_err - e0), 32'd1);
        chk("t5_no_start", 32'(n_start - s0), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        send_frame(NPIX, NPIX - 1, 6000, rej);
        wait_rx("t5", NPIX);
        check_frame("t5", 0, 6000);
        pulse_done();

        // 6) reset during load and during replay
        rx.delete();
        send_frame(400, -1, 0, rej);
        rstn = 1'b0;
        #1 chk_reset_outs("t6_load");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send_frame(NPIX, NPIX - 1, 7000, rej);
        wait_rx("t6_mid", 300);
        @(negedge clk);
        rstn = 1'b0;
        #1 chk_reset_outs("t6_replay");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        rx.delete();
        s0 = n_start;
        send_frame(NPIX, NPIX - 1, 8000, rej);
        wait_rx("t6", NPIX);
        check_frame("t6", 0, 8000);
        chk("t6_starts", 32'(n_start - s0), 32'd1);
        pulse_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule : tb_image_feeder
`default_nettype wire
